aclk_core: RTL and testbench
============================

# aclk_core

Alarm-clock core: the design under test driven and monitored through the team's alarm-clock bench interface. It derives real-time seconds from a 10 Hz clock, keeps a BCD 24-hour time of day, holds a loadable alarm time, and raises `Alarm` when the time of day reaches the alarm time while the alarm function is enabled. All inputs are sampled on `clk`. All outputs are registered.

## Interface
- `TICKS_PER_SEC`, default 10: clk cycles per second. Must be ≥ 2.
- `clk` in 1: 10 Hz clock. All state updates on the rising edge.
- `reset` in 1: reset is asynchronous and active-high. It clears time, alarm registers, tick counter and `Alarm`.
- `H_in1` in 2: hour tens digit for a load, range 0-2.
- `H_in0` in 4: hour units digit for a load, range 0-9.
- `M_in1` in 4: minute tens digit for a load, range 0-5.
- `M_in0` in 4: minute units digit for a load, range 0-9.
- `LD_time` in 1: load the time of day from the `*_in` digits.
- `LD_alarm` in 1: load the alarm time from the `*_in` digits.
- `STOP_al` in 1: clear `Alarm`.
- `AL_ON` in 1: alarm function enable.
- `Alarm` out 1: alarm active, latched.
- `H_out1` out 2, `H_out0` out 4: hour, BCD.
- `M_out1` out 4, `M_out0` out 4: minute, BCD.
- `S_out1` out 4, `S_out0` out 4: second, BCD.

## Operation
- **Reset.** While `reset`=1, every output is 0. Time reads 00:00:00, alarm time is 00:00, tick counter is 0, `Alarm`=0.
- **Tick counter.** Counts 0..`TICKS_PER_SEC`-1. On the edge where it equals `TICKS_PER_SEC`-1, it wraps to 0 and the time advances by one second.
- **BCD carry chain.**
  - `S_out0` wraps 9→0 and carries into `S_out1`.
  - `S_out1` wraps 5→0 and carries into `M_out0`.
  - Minutes carry the same way into `H_out0`.
  - Hours: 09→10, 19→20, 23→00.
  - 23:59:59 plus one second gives 00:00:00. Only the time changes; alarm registers are unaffected.
- **Input validity.** A load is valid only if hour ≤ 23 and minute ≤ 59, with every digit in range (`H_in1`≤2; `H_in0`≤3 when `H_in1`=2; `M_in1`≤5; `M_in0`≤9). An invalid load leaves the target registers unchanged. Ignoring an invalid `LD_time` also means no tick reset.
- **`LD_time`, valid.**
  - Hours and minutes take the input digits; seconds become 00.
  - The tick counter becomes 0.
  - This overrides the normal second advance on the same edge.
- **`LD_alarm`, valid.** Alarm hour and minute take the input digits. The time of day is unaffected.
- **Simultaneous loads.** `LD_time` and `LD_alarm` on the same edge both take effect, with the same digits.
- **Match.** True when the current registered time equals the alarm hour and minute with seconds 00. Loaded alarm times only; no match is generated on reset state unless alarm time 00:00 was loaded or left at its reset value.
- **`Alarm` update, per edge, in priority order:**
  1. If `STOP_al`=1 or `AL_ON`=0, `Alarm` becomes 0.
  2. Otherwise, if match, `Alarm` becomes 1.
  3. Otherwise `Alarm` holds.
- `Alarm` stays latched after the match second passes, until it is stopped or disabled.

## Timing
- Loads take effect on the first rising edge where `LD_*`=1, and are visible on the outputs immediately after that edge.
- After a valid `LD_time` edge, `S_out0`=1 appears after exactly `TICKS_PER_SEC` further edges (10 with the default).
- Holding `LD_time` high holds seconds at 00 and the tick counter at 0.
- `Alarm` rises one edge after the registered time first equals the alarm time with seconds 00. That is the edge after the time display changes to HH:MM:00.
- The match is present for `TICKS_PER_SEC` edges, so `Alarm` is re-set on the edge after `STOP_al` deasserts if the match is still present.
- `STOP_al` and match on the same edge: `Alarm`=0, because stop wins.
- Reset asserted mid-operation clears all state asynchronously, without waiting for a clock edge. Counting resumes from 00:00:00 on the first edge after deassertion; the tick counter starts at 0.

## Test plan
- **Reset values.** Assert `reset` mid-count at 12:34:56 → all outputs 0 immediately. Release, then 10 edges → 00:00:01.
- **Load and count.** `LD_time` with 23:59 for one edge → 23:59:00. After 590 edges → 23:59:59. One further second (10 edges) → 00:00:00, with no alarm since `AL_ON`=0.
- **Invalid load.** `LD_time` with `H_in1`=2, `H_in0`=4 → time unchanged and tick counter not cleared. `LD_alarm` with `M_in1`=6 → alarm unchanged.
- **Alarm hit.** `AL_ON`=1; `LD_alarm` 07:30; `LD_time` 07:29. After 600 edges, time reads 07:30:00; `Alarm`=1 exactly one edge later, and stays 1 through 07:31:00.
- **Stop and disable.**
  - With `Alarm`=1, pulse `STOP_al` during 07:30:05 → `Alarm`=0 and stays 0.
  - Repeat with `STOP_al` pulsed during 07:30:00 → `Alarm` re-asserts on the edge after `STOP_al` falls.
  - `AL_ON`=0 at any point → `Alarm`=0 next edge.
- **Simultaneous loads.** `LD_time` and `LD_alarm` both 1 with 12:00, `AL_ON`=1 → time 12:00:00 and alarm 12:00 after that edge; `Alarm`=1 on the following edge.

Source files
------------

// File: rtl/aclk_if.sv
// Alarm-clock bench bus: load digits and controls toward the core,
// registered BCD time and the latched alarm back from it.
interface aclk_if;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time;
  logic       LD_alarm;
  logic       STOP_al;
  logic       AL_ON;
  logic       Alarm;
  logic [1:0] H_out1;
  logic [3:0] H_out0;
  logic [3:0] M_out1;
  logic [3:0] M_out0;
  logic [3:0] S_out1;
  logic [3:0] S_out0;

  // Bench / controller side: drives loads and controls, watches the display.
  modport master (
    output H_in1, H_in0, M_in1, M_in0,
    output LD_time, LD_alarm, STOP_al, AL_ON,
    input  Alarm, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0
  );

  // Core side.
  modport slave (
    input  H_in1, H_in0, M_in1, M_in0,
    input  LD_time, LD_alarm, STOP_al, AL_ON,
    output Alarm, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0
  );
endinterface

// File: rtl/aclk_core.sv
// Alarm-clock core: divides clk down to seconds, keeps a BCD 24-hour time of
// day, holds a loadable alarm time and latches Alarm when the time reaches
// HH:MM:00 of the alarm while the alarm function is enabled.
module aclk_core #(
  parameter int TICKS_PER_SEC = 10
) (
  input  logic  clk,
  input  logic  reset,
  aclk_if.slave bus
);

  localparam int TICK_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

  logic [TICK_W-1:0] tick_cnt;

  logic [1:0] h1_q;
  logic [3:0] h0_q;
  logic [3:0] m1_q;
  logic [3:0] m0_q;
  logic [3:0] s1_q;
  logic [3:0] s0_q;

  logic [1:0] h1_n;
  logic [3:0] h0_n;
  logic [3:0] m1_n;
  logic [3:0] m0_n;
  logic [3:0] s1_n;
  logic [3:0] s0_n;

  logic [1:0] al_h1_q;
  logic [3:0] al_h0_q;
  logic [3:0] al_m1_q;
  logic [3:0] al_m0_q;

  logic       alarm_q;

  logic       load_valid;
  logic       sec_tick;
  logic       time_load;
  logic       alarm_load;
  logic       match;

  // A load is accepted only for a real 00:00..23:59 time with every digit in range.
  always_comb begin
    load_valid = 1'b1;
    if (bus.H_in1 > 2'd2) begin
      load_valid = 1'b0;
    end
    if (bus.H_in0 > 4'd9) begin
      load_valid = 1'b0;
    end
    if ((bus.H_in1 == 2'd2) && (bus.H_in0 > 4'd3)) begin
      load_valid = 1'b0;
    end
    if (bus.M_in1 > 4'd5) begin
      load_valid = 1'b0;
    end
    if (bus.M_in0 > 4'd9) begin
      load_valid = 1'b0;
    end
  end

  assign sec_tick   = (tick_cnt == TICK_LAST);
  assign time_load  = bus.LD_time && load_valid;
  assign alarm_load = bus.LD_alarm && load_valid;

  // Time one second later, rippling the BCD carry from seconds up to hours.
  always_comb begin
    h1_n = h1_q;
    h0_n = h0_q;
    m1_n = m1_q;
    m0_n = m0_q;
    s1_n = s1_q;
    s0_n = s0_q;
    if (s0_q != 4'd9) begin
      s0_n = s0_q + 4'd1;
    end else begin
      s0_n = 4'd0;
      if (s1_q != 4'd5) begin
        s1_n = s1_q + 4'd1;
      end else begin
        s1_n = 4'd0;
        if (m0_q != 4'd9) begin
          m0_n = m0_q + 4'd1;
        end else begin
          m0_n = 4'd0;
          if (m1_q != 4'd5) begin
            m1_n = m1_q + 4'd1;
          end else begin
            m1_n = 4'd0;
            if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
              h1_n = 2'd0;
              h0_n = 4'd0;
            end else if (h0_q == 4'd9) begin
              h0_n = 4'd0;
              h1_n = h1_q + 2'd1;
            end else begin
              h0_n = h0_q + 4'd1;
            end
          end
        end
      end
    end
  end

  // Alarm matches only on the whole minute, so it is present for one second.
  always_comb begin
    match = (h1_q == al_h1_q) && (h0_q == al_h0_q) &&
            (m1_q == al_m1_q) && (m0_q == al_m0_q) &&
            (s1_q == 4'd0)    && (s0_q == 4'd0);
  end

  // Tick divider; a valid time load restarts the second from its beginning.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (time_load || sec_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Time of day: a valid load wins over the normal second advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h1_q <= 2'd0;
      h0_q <= 4'd0;
      m1_q <= 4'd0;
      m0_q <= 4'd0;
      s1_q <= 4'd0;
      s0_q <= 4'd0;
    end else if (time_load) begin
      h1_q <= bus.H_in1;
      h0_q <= bus.H_in0;
      m1_q <= bus.M_in1;
      m0_q <= bus.M_in0;
      s1_q <= 4'd0;
      s0_q <= 4'd0;
    end else if (sec_tick) begin
      h1_q <= h1_n;
      h0_q <= h0_n;
      m1_q <= m1_n;
      m0_q <= m0_n;
      s1_q <= s1_n;
      s0_q <= s0_n;
    end
  end

  // Alarm time register, loaded from the same digits as the time of day.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      al_h1_q <= 2'd0;
      al_h0_q <= 4'd0;
      al_m1_q <= 4'd0;
      al_m0_q <= 4'd0;
    end else if (alarm_load) begin
      al_h1_q <= bus.H_in1;
      al_h0_q <= bus.H_in0;
      al_m1_q <= bus.M_in1;
      al_m0_q <= bus.M_in0;
    end
  end

  // Latched alarm: stop or disable clears it, a match sets it, else it holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_q <= 1'b0;
    end else if (bus.STOP_al || !bus.AL_ON) begin
      alarm_q <= 1'b0;
    end else if (match) begin
      alarm_q <= 1'b1;
    end
  end

  assign bus.Alarm  = alarm_q;
  assign bus.H_out1 = h1_q;
  assign bus.H_out0 = h0_q;
  assign bus.M_out1 = m1_q;
  assign bus.M_out0 = m0_q;
  assign bus.S_out1 = s1_q;
  assign bus.S_out0 = s0_q;

endmodule

// File: tb/tb_aclk_core.sv
// Bench for aclk_core: a table of timed stimulus records, each pushing its
// expected display and Alarm into a scoreboard queue that is popped and
// compared once the record's clock edges have elapsed.
module tb_aclk_core;

  typedef struct {
    string name;
    int    h;
    int    m;
    bit    ld_time;
    bit    ld_alarm;
    bit    stop_al;
    bit    al_on;
    int    edges;
    int    exp_h;
    int    exp_m;
    int    exp_s;
    bit    exp_alarm;
  } vec_t;

  typedef struct {
    string       name;
    logic [21:0] bcd;
    logic        alarm;
  } exp_t;

  logic clk;
  logic reset;
  aclk_if bus ();

  exp_t exp_q[$];
  vec_t vecs[$];
  int   checks_total;
  int   checks_passed;

  aclk_core #(.TICKS_PER_SEC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish (actual running, required finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [21:0] to_bcd(int h, int m, int s);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic vec_t mk(string name, int h, int m, bit ldt, bit lda, bit stop,
                              bit alon, int edges, int eh, int em, int es, bit eal);
    vec_t v;
    v.name = name;      v.h = h;            v.m = m;
    v.ld_time = ldt;    v.ld_alarm = lda;   v.stop_al = stop;  v.al_on = alon;
    v.edges = edges;    v.exp_h = eh;       v.exp_m = em;      v.exp_s = es;
    v.exp_alarm = eal;
    return v;
  endfunction

  function automatic vec_t idle(string name, bit alon, int edges, int eh, int em, int es, bit eal);
    return mk(name, 0, 0, 1'b0, 1'b0, 1'b0, alon, edges, eh, em, es, eal);
  endfunction

  task automatic push_expect(string name, int h, int m, int s, bit al);
    exp_t e;
    e.name  = name;
    e.bcd   = to_bcd(h, m, s);
    e.alarm = al;
    exp_q.push_back(e);
  endtask

  // Pops the oldest expectation and compares it with the DUT display/Alarm.
  task automatic checkOutput();
    exp_t        e;
    logic [21:0] got;
    checks_total++;
    if (exp_q.size() == 0) begin
      $display("[TB] FAIL scoreboard: queue empty (actual 0 entries, required >=1)");
      return;
    end
    e = exp_q.pop_front();
    got = {bus.H_out1, bus.H_out0, bus.M_out1, bus.M_out0, bus.S_out1, bus.S_out0};
    if (got === e.bcd) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s time: actual %h:%h:%h, required %h:%h:%h", e.name,
               got[21:14], got[13:6], got[5:0], e.bcd[21:14], e.bcd[13:6], e.bcd[5:0]);
    end
    checks_total++;
    if (bus.Alarm === e.alarm) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s alarm: actual %b, required %b", e.name, bus.Alarm, e.alarm);
    end
  endtask

  // Drives one record, lets its edges elapse and checks on the falling edge.
  task automatic applyStimulus(vec_t v);
    bus.H_in1    = 2'(v.h / 10);
    bus.H_in0    = 4'(v.h % 10);
    bus.M_in1    = 4'(v.m / 10);
    bus.M_in0    = 4'(v.m % 10);
    bus.LD_time  = v.ld_time;
    bus.LD_alarm = v.ld_alarm;
    bus.STOP_al  = v.stop_al;
    bus.AL_ON    = v.al_on;
    push_expect(v.name, v.exp_h, v.exp_m, v.exp_s, v.exp_alarm);
    repeat (v.edges) @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    bus.H_in1 = 2'd0;   bus.H_in0 = 4'd0;   bus.M_in1 = 4'd0;  bus.M_in0 = 4'd0;
    bus.LD_time = 1'b0; bus.LD_alarm = 1'b0; bus.STOP_al = 1'b0; bus.AL_ON = 1'b0;
    reset = 1'b1;

    repeat (2) @(negedge clk);
    push_expect("reset state", 0, 0, 0, 1'b0);
    checkOutput();
    reset = 1'b0;

    // Asynchronous reset in the middle of counting.
    applyStimulus(mk("load 12:34", 12, 34, 1, 0, 0, 0, 1, 12, 34, 0, 0));
    applyStimulus(idle("count to 12:34:56", 0, 560, 12, 34, 56, 0));
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    push_expect("async reset", 0, 0, 0, 1'b0);
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(idle("count after reset", 0, 10, 0, 0, 1, 0));

    vecs.push_back(mk  ("load 23:59",         23, 59, 1, 0, 0, 0, 1,   23, 59, 0, 0));
    vecs.push_back(idle("count to 23:59:59",  0, 590,                  23, 59, 59, 0));
    vecs.push_back(idle("midnight wrap",      0, 10,                   0, 0, 0, 0));
    vecs.push_back(idle("partial second",     0, 3,                    0, 0, 0, 0));
    vecs.push_back(mk  ("invalid time 24:00", 24, 0, 1, 0, 0, 0, 1,    0, 0, 0, 0));
    vecs.push_back(idle("tick not cleared",   0, 6,                    0, 0, 1, 0));
    vecs.push_back(mk  ("invalid time 15:60", 15, 60, 1, 0, 0, 0, 1,   0, 0, 1, 0));
    vecs.push_back(idle("after invalid min",  0, 9,                    0, 0, 2, 0));
    vecs.push_back(mk  ("load alarm 07:30",   7, 30, 0, 1, 0, 1, 1,    0, 0, 2, 0));
    vecs.push_back(mk  ("load time 07:29",    7, 29, 1, 0, 0, 1, 1,    7, 29, 0, 0));
    vecs.push_back(idle("to 07:29:59",        1, 599,                  7, 29, 59, 0));
    vecs.push_back(idle("reach 07:30:00",     1, 1,                    7, 30, 0, 0));
    vecs.push_back(idle("alarm rises",        1, 1,                    7, 30, 0, 1));
    vecs.push_back(idle("latched to 07:31",   1, 599,                  7, 31, 0, 1));
    vecs.push_back(mk  ("reload 07:30",       7, 30, 1, 0, 0, 1, 1,    7, 30, 0, 1));
    vecs.push_back(idle("to 07:30:05",        1, 50,                   7, 30, 5, 1));
    vecs.push_back(mk  ("stop at :05",        0, 0, 0, 0, 1, 1, 1,     7, 30, 5, 0));
    vecs.push_back(idle("stays stopped",      1, 100,                  7, 30, 15, 0));
    vecs.push_back(mk  ("reload 07:30 b",     7, 30, 1, 0, 0, 1, 1,    7, 30, 0, 0));
    vecs.push_back(mk  ("stop beats match",   0, 0, 0, 0, 1, 1, 1,     7, 30, 0, 0));
    vecs.push_back(idle("re-set after stop",  1, 1,                    7, 30, 0, 1));
    vecs.push_back(idle("disable clears",     0, 1,                    7, 30, 0, 0));
    vecs.push_back(idle("disabled counting",  0, 7,                    7, 30, 1, 0));
    vecs.push_back(mk  ("invalid alarm 08:61", 8, 61, 0, 1, 0, 1, 1,   7, 30, 1, 0));
    vecs.push_back(mk  ("reload 07:30 c",     7, 30, 1, 0, 0, 1, 1,    7, 30, 0, 0));
    vecs.push_back(idle("alarm kept 07:30",   1, 1,                    7, 30, 0, 1));
    vecs.push_back(idle("disable again",      0, 1,                    7, 30, 0, 0));
    vecs.push_back(idle("drift off match",    0, 8,                    7, 30, 1, 0));
    vecs.push_back(mk  ("dual load 12:00",    12, 0, 1, 1, 0, 1, 1,    12, 0, 0, 0));
    vecs.push_back(idle("dual load alarm",    1, 1,                    12, 0, 0, 1));
    vecs.push_back(mk  ("hold LD_time",       12, 0, 1, 0, 0, 1, 25,   12, 0, 0, 1));
    vecs.push_back(idle("release hold",       1, 10,                   12, 0, 1, 1));
    vecs.push_back(mk  ("load 09:59",         9, 59, 1, 0, 0, 0, 1,    9, 59, 0, 0));
    vecs.push_back(idle("carry to 10:00",     0, 600,                  10, 0, 0, 0));
    vecs.push_back(mk  ("load 19:59",         19, 59, 1, 0, 0, 0, 1,   19, 59, 0, 0));
    vecs.push_back(idle("carry to 20:00",     0, 600,                  20, 0, 0, 0));
    vecs.push_back(mk  ("invalid hour 30:00", 30, 0, 1, 0, 0, 0, 1,    20, 0, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
    end

    if (exp_q.size() != 0) begin
      checks_total++;
      $display("[TB] FAIL scoreboard drain: actual %0d entries, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
